// File: rtl/rr_arb_hold.sv
// Round-robin arbiter with held grant tenures: a grant lasts until the request drops,
// WEIGHT beats complete (unless locked), or the tenure sits idle for TIMEOUT_CNT_MAX cycles.
module rr_arb_hold #(
  parameter int NREQ            = 4,
  parameter int WEIGHT          = 4,
  parameter int TIMEOUT_CNT_MAX = 32,
  parameter int IDX_WIDTH       = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      reqBus,
  input  logic                 lock,
  input  logic                 beat,
  output logic [NREQ-1:0]      grantBus,
  output logic                 grantValid,
  output logic [IDX_WIDTH-1:0] grantIdx,
  output logic                 timeoutEvt
);
  localparam int BW = $clog2(WEIGHT + 1);
  localparam int TW = $clog2(TIMEOUT_CNT_MAX + 1);

  // state | meaning
  // IDLE  | no tenure; pick a winner from base when any request is up
  // GRANT | tenure in progress; count beats and idle cycles until release
  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_nxt;
  logic [NREQ-1:0]      base, base_nxt;
  logic [NREQ-1:0]      grant_nxt;
  logic [IDX_WIDTH-1:0] idx_nxt;
  logic [BW-1:0]        beat_cnt, beat_cnt_nxt, beat_inc;
  logic [TW-1:0]        idle_cnt, idle_cnt_nxt, idle_inc;
  logic                 timeout_nxt;
  logic [NREQ-1:0]      win_oh;
  logic [IDX_WIDTH-1:0] win_idx;
  logic [IDX_WIDTH-1:0] base_idx;
  logic                 found;
  logic                 rel_drop, rel_weight, rel_timeout;

  // Search starts at the pointer and wraps past the top requester.
  always_comb begin
    int j;
    win_oh   = '0;
    win_idx  = '0;
    base_idx = '0;
    found    = 1'b0;
    j        = 0;
    for (int i = 0; i < NREQ; i++)
      if (base[i]) base_idx = IDX_WIDTH'(i);
    for (int k = 0; k < NREQ; k++) begin
      j = int'(base_idx) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && reqBus[j]) begin
        found      = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = IDX_WIDTH'(j);
      end
    end
  end

  always_comb begin
    beat_inc = beat_cnt;
    if (beat && (beat_cnt != BW'(WEIGHT))) beat_inc = beat_cnt + BW'(1);
    idle_inc = '0;
    if (!beat)
      idle_inc = (idle_cnt == TW'(TIMEOUT_CNT_MAX)) ? idle_cnt : idle_cnt + TW'(1);
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grantBus;
    idx_nxt      = grantIdx;
    base_nxt     = base;
    beat_cnt_nxt = beat_cnt;
    idle_cnt_nxt = idle_cnt;
    timeout_nxt  = 1'b0;
    rel_drop     = 1'b0;
    rel_weight   = 1'b0;
    rel_timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (|reqBus) begin
          grant_nxt = win_oh;
          idx_nxt   = win_idx;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        beat_cnt_nxt = beat_inc;
        idle_cnt_nxt = idle_inc;
        rel_drop     = ~|(reqBus & grantBus);
        rel_weight   = (beat_inc == BW'(WEIGHT)) && !lock;
        rel_timeout  = (idle_inc == TW'(TIMEOUT_CNT_MAX));
        if (rel_drop || rel_weight || rel_timeout) begin
          grant_nxt    = '0;
          idx_nxt      = '0;
          base_nxt     = {grantBus[NREQ-2:0], grantBus[NREQ-1]};
          beat_cnt_nxt = '0;
          idle_cnt_nxt = '0;
          timeout_nxt  = rel_timeout;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= NREQ'(1);
      grantBus   <= '0;
      grantValid <= 1'b0;
      grantIdx   <= '0;
      timeoutEvt <= 1'b0;
      beat_cnt   <= '0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      base       <= base_nxt;
      grantBus   <= grant_nxt;
      grantValid <= |grant_nxt;
      grantIdx   <= idx_nxt;
      timeoutEvt <= timeout_nxt;
      beat_cnt   <= beat_cnt_nxt;
      idle_cnt   <= idle_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_rr_arb_hold.sv
// Bench for rr_arb_hold: directed scenarios with literal grant sequences, then random
// traffic compared every cycle against a tenure-level reference model.
module tb_rr_arb_hold;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int T    = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] reqBus = '0;
  logic            lock = 1'b0;
  logic            beat = 1'b0;
  logic [NREQ-1:0] grantBus;
  logic            grantValid;
  logic [1:0]      grantIdx;
  logic            timeoutEvt;

  int checks = 0;
  int errors = 0;

  rr_arb_hold #(.NREQ(NREQ), .WEIGHT(W), .TIMEOUT_CNT_MAX(T)) dut (
    .clk(clk), .rst(rst), .reqBus(reqBus), .lock(lock), .beat(beat),
    .grantBus(grantBus), .grantValid(grantValid), .grantIdx(grantIdx),
    .timeoutEvt(timeoutEvt)
  );

  always #5 clk = ~clk;

  // Reference: who holds the bus (-1 = nobody), next-priority index, beats and idle cycles so far.
  typedef struct {
    int holder;
    int base;
    int bcnt;
    int icnt;
    bit to;
  } mstate_t;

  localparam mstate_t M_RESET = '{holder: -1, base: 0, bcnt: 0, icnt: 0, to: 1'b0};
  mstate_t m = M_RESET;

  function automatic mstate_t mnext(mstate_t s, logic [NREQ-1:0] r, logic lk, logic bt);
    mstate_t n;
    int bc, ic, c;
    n = s;
    n.to = 1'b0;
    if (s.holder < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        c = (s.base + k) % NREQ;
        if (n.holder < 0 && r[c]) n.holder = c;
      end
      n.bcnt = 0;
      n.icnt = 0;
    end else begin
      bc = bt ? ((s.bcnt < W) ? s.bcnt + 1 : W) : s.bcnt;
      ic = bt ? 0 : ((s.icnt < T) ? s.icnt + 1 : T);
      if (!r[s.holder] || (bc == W && !lk) || ic == T) begin
        n.to     = (ic == T);
        n.base   = (s.holder + 1) % NREQ;
        n.holder = -1;
        n.bcnt   = 0;
        n.icnt   = 0;
      end else begin
        n.bcnt = bc;
        n.icnt = ic;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= M_RESET;
    else     m <= mnext(m, reqBus, lock, beat);
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_grantBus",   int'(grantBus),   (m.holder < 0) ? 0 : (1 << m.holder));
      chk("cmp_grantValid", int'(grantValid), (m.holder < 0) ? 0 : 1);
      chk("cmp_grantIdx",   int'(grantIdx),   (m.holder < 0) ? 0 : m.holder);
      chk("cmp_timeoutEvt", int'(timeoutEvt), int'(m.to));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; reqBus = '0; lock = 1'b0; beat = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic obs(output int v);
    @(negedge clk);
    v = grantValid ? int'(grantIdx) : -1;
  endtask

  task automatic async_rst_check(string name);
    #2 rst = 1'b1;
    #1;
    chk({name, "_bus"},   int'(grantBus),   0);
    chk({name, "_valid"}, int'(grantValid), 0);
    chk({name, "_idx"},   int'(grantIdx),   0);
    chk({name, "_to"},    int'(timeoutEvt), 0);
  endtask

  initial begin
    int v;
    int e1[$] = '{0,0,0,0,-1,1,1,1,1,-1,2,2,2,2,-1,3,3,3,3,-1,0,0,0,0};
    int e4[$] = '{1,1,1,1,-1,3,3,3,3,-1,1,1,1,1};
    int beat_pct;

    rst = 1'b1;
    do_reset();
    chk("reset_valid", int'(grantValid), 0);
    chk("reset_bus",   int'(grantBus),   0);

    // all requesting, beat every cycle: four-beat tenures in order with bubbles
    reqBus = 4'b1111; beat = 1'b1; lock = 1'b0;
    foreach (e1[i]) begin obs(v); chk("rr_all_seq", v, e1[i]); end

    // locked tenure of 10 beats ends on request drop; pointer moves to 1
    do_reset();
    reqBus = 4'b0001; lock = 1'b1; beat = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      obs(v);
      chk("lock_seq", v, (i <= 10) ? 0 : ((i == 11) ? -1 : 1));
      if (i == 10) reqBus = 4'b0000;
      if (i == 11) begin reqBus = 4'b0011; lock = 1'b0; end
    end

    // timeout on req2 with lock and no beats; next grant req3
    do_reset();
    reqBus = 4'b0100; lock = 1'b1; beat = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      obs(v);
      chk("to_seq", v, (i <= 8) ? 2 : ((i == 9) ? -1 : 3));
      chk("to_pulse", int'(timeoutEvt), (i == 9) ? 1 : 0);
      if (i == 1) reqBus = 4'b1100;
    end

    // alternate requesters only
    do_reset();
    reqBus = 4'b1010; beat = 1'b1; lock = 1'b0;
    foreach (e4[i]) begin obs(v); chk("odd_seq", v, e4[i]); end

    // async reset mid-tenure on req3, then req0 wins from the reset pointer
    do_reset();
    reqBus = 4'b1000; beat = 1'b0; lock = 1'b0;
    for (int i = 0; i < 3; i++) begin obs(v); chk("pre_rst_seq", v, 3); end
    async_rst_check("async_rst");
    @(negedge clk);
    rst = 1'b0; reqBus = 4'b1001;
    obs(v); chk("post_rst_first", v, 0);

    // random traffic against the model
    beat_pct = 60;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (n % 200 == 0) beat_pct = (n / 200) % 3 == 0 ? 5 : ((n / 200) % 3 == 1 ? 50 : 90);
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 7) == 0) reqBus[b] = ~reqBus[b];
      beat = ($urandom_range(0, 99) < beat_pct);
      lock = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 399) == 0) begin
        async_rst_check("rand_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
